// File: rtl/note_player_pkg.sv
// Shared constants, state encoding and pitch table for the note player.
package note_pkg;

  localparam int NOTE_W   = 4;
  localparam int NUM_KEYS = 8;

  localparam logic [NOTE_W-1:0] NOTE_SILENT = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_MIN    = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_MAX    = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } state_t;

  // Half-periods in cycles at 10 MHz: C4 D4 E4 F4 G4 A4 B4 C5.
  localparam int unsigned HALF_PERIOD [NUM_KEYS] = '{
    19111, 17026, 15169, 14317, 12755, 11364, 10124, 9556
  };

  // Scaled half-period for a valid note code, never less than one cycle.
  // Codes outside 1..8 wrap to a harmless table entry; callers only use the
  // result while a valid note is loaded or sounding.
  function automatic int unsigned half_period(input logic [NOTE_W-1:0] code,
                                              input int unsigned shift);
    int unsigned hp;
    logic [2:0]  idx;
    idx = 3'(code - NOTE_MIN);
    hp  = HALF_PERIOD[idx] >> shift;
    if (hp == 0) hp = 1;
    return hp;
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Sequencer-to-player connection: note code in, tone and status out.
interface note_player_if;
  import note_pkg::*;

  logic [NOTE_W-1:0] note_sustain;
  logic              wave;
  logic              active;
  logic              releasing;
  logic [NOTE_W-1:0] cur_note;
  logic              note_start;

  // Sequencer side drives the note code and observes the player.
  modport master (
    output note_sustain,
    input  wave, active, releasing, cur_note, note_start
  );

  // Player side.
  modport slave (
    input  note_sustain,
    output wave, active, releasing, cur_note, note_start
  );
endinterface

// File: rtl/note_player_tone_divider.sv
// Square-wave generator: counts down a half-period and toggles the output.
module tone_divider #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] half,
  input  logic             run,
  output logic             wave,
  output logic [CNT_W-1:0] div_cnt
);

  // Load restarts the phase high; while running, toggle on terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wave    <= 1'b0;
      div_cnt <= '0;
    end else if (load) begin
      wave    <= 1'b1;
      div_cnt <= half - CNT_W'(1);
    end else if (!run) begin
      wave    <= 1'b0;
      div_cnt <= '0;
    end else if (div_cnt == '0) begin
      wave    <= ~wave;
      div_cnt <= half - CNT_W'(1);
    end else begin
      div_cnt <= div_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_player.sv
// Note code to square-wave tone: trigger/decode, release tail and FSM.
module note_player
  import note_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned DIV_SHIFT      = 0,
  parameter int unsigned RELEASE_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst,
  note_player_if.slave bus
);

  localparam logic [CNT_W-1:0] REL_LOAD =
    (RELEASE_CYCLES > 0) ? CNT_W'(RELEASE_CYCLES - 1) : '0;

  state_t            state_reg, state_next;
  logic [NOTE_W-1:0] cur_note_reg, cur_note_next;
  logic [CNT_W-1:0]  rel_cnt_reg, rel_cnt_next;
  logic              note_start_reg;

  logic              code_valid;
  logic              trigger;
  logic              run;
  logic [CNT_W-1:0]  half_sel;

  // Decode the live note code; a new or restarted note beats everything else.
  always_comb begin
    code_valid    = (bus.note_sustain >= NOTE_MIN) && (bus.note_sustain <= NOTE_MAX);
    trigger       = code_valid &&
                    ((state_reg != PLAY) || (bus.note_sustain != cur_note_reg));
    state_next    = state_reg;
    cur_note_next = cur_note_reg;
    rel_cnt_next  = rel_cnt_reg;

    if (trigger) begin
      state_next    = PLAY;
      cur_note_next = bus.note_sustain;
    end else begin
      case (state_reg)
        PLAY: begin
          // Not a trigger and valid means the same note is held.
          if (!code_valid) begin
            if (RELEASE_CYCLES > 0) begin
              state_next   = RELEASE;
              rel_cnt_next = REL_LOAD;
            end else begin
              state_next    = IDLE;
              cur_note_next = NOTE_SILENT;
            end
          end
        end
        RELEASE: begin
          if (rel_cnt_reg == '0) begin
            state_next    = IDLE;
            cur_note_next = NOTE_SILENT;
          end else begin
            rel_cnt_next = rel_cnt_reg - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // New note loads its own pitch; otherwise keep reloading the sounding one.
    half_sel = CNT_W'(half_period(trigger ? bus.note_sustain : cur_note_reg, DIV_SHIFT));
    run      = (state_next != IDLE);
  end

  // State, sounding note, release counter and trigger pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cur_note_reg   <= NOTE_SILENT;
      rel_cnt_reg    <= '0;
      note_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_note_reg   <= cur_note_next;
      rel_cnt_reg    <= rel_cnt_next;
      note_start_reg <= trigger;
    end
  end

  tone_divider #(.CNT_W(CNT_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .load    (trigger),
    .half    (half_sel),
    .run     (run),
    .wave    (bus.wave),
    .div_cnt ()
  );

  assign bus.active     = (state_reg != IDLE);
  assign bus.releasing  = (state_reg == RELEASE);
  assign bus.cur_note   = cur_note_reg;
  assign bus.note_start = note_start_reg;

endmodule

// File: tb/tb_note_player.sv
// Two player instances (slow pitch with tail, clamped pitch without tail)
// driven together and compared every cycle against a phase-based model.
module tb_note_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  note_player_if bus_a ();
  note_player_if bus_b ();

  note_player #(.CNT_W(16), .DIV_SHIFT(8), .RELEASE_CYCLES(100)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  note_player #(.CNT_W(16), .DIV_SHIFT(15), .RELEASE_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int total = 0;
  int bad   = 0;

  // Model: which note sounds, cycles since its trigger, release tail left.
  int shift_k [2] = '{8, 15};
  int relc_k  [2] = '{100, 0};
  int hp_tab  [8] = '{19111, 17026, 15169, 14317, 12755, 11364, 10124, 9556};
  int m_note  [2] = '{0, 0};
  int m_t     [2] = '{0, 0};
  int m_left  [2] = '{0, 0};
  bit m_rel   [2] = '{1'b0, 1'b0};
  bit m_start [2] = '{1'b0, 1'b0};

  function automatic int half_of(int code, int sh);
    int h;
    h = hp_tab[code - 1] >> sh;
    if (h < 1) h = 1;
    return h;
  endfunction

  task automatic model_step(int k, int code, bit r);
    bit valid, trig;
    valid = (code >= 1) && (code <= 8);
    trig  = valid && (m_note[k] == 0 || m_rel[k] || code != m_note[k]);
    if (r) begin
      m_note[k] = 0; m_t[k] = 0; m_left[k] = 0; m_rel[k] = 0; m_start[k] = 0;
    end else if (trig) begin
      m_note[k] = code; m_t[k] = 0; m_rel[k] = 0; m_start[k] = 1;
    end else begin
      m_start[k] = 0;
      if (m_note[k] != 0) begin
        m_t[k]++;
        if (m_rel[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_note[k] = 0;
            m_rel[k]  = 0;
          end
        end else if (code != m_note[k]) begin
          if (relc_k[k] > 0) begin
            m_rel[k]  = 1;
            m_left[k] = relc_k[k];
          end else begin
            m_note[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(string tag, int k, string field, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s dut%0d %s: got %0d want %0d", tag, k, field, obs, exp);
    end
  endtask

  task automatic check_dut(int k, string tag);
    logic [3:0] wave_o, act_o, rel_o, note_o, start_o;
    bit exp_wave;
    if (k == 0) begin
      wave_o = {3'b0, bus_a.wave};      act_o = {3'b0, bus_a.active};
      rel_o  = {3'b0, bus_a.releasing}; note_o = bus_a.cur_note;
      start_o = {3'b0, bus_a.note_start};
    end else begin
      wave_o = {3'b0, bus_b.wave};      act_o = {3'b0, bus_b.active};
      rel_o  = {3'b0, bus_b.releasing}; note_o = bus_b.cur_note;
      start_o = {3'b0, bus_b.note_start};
    end
    exp_wave = (m_note[k] != 0) && (((m_t[k] / half_of(m_note[k], shift_k[k])) % 2) == 0);
    chk(tag, k, "wave",       wave_o,  {3'b0, exp_wave});
    chk(tag, k, "active",     act_o,   {3'b0, m_note[k] != 0});
    chk(tag, k, "releasing",  rel_o,   {3'b0, m_rel[k]});
    chk(tag, k, "cur_note",   note_o,  4'(m_note[k]));
    chk(tag, k, "note_start", start_o, {3'b0, m_start[k]});
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step(0, int'(bus_a.note_sustain), rst_a);
    model_step(1, int'(bus_b.note_sustain), rst_b);
    #1;
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  task automatic run(int code, int n, string tag);
    bus_a.note_sustain = 4'(code);
    bus_b.note_sustain = 4'(code);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int code, hold;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Reset with a note requested: everything stays silent.
    run(6, 5, "reset");
    rst_a = 1'b0;
    rst_b = 1'b0;
    run(0, 3, "idle_after_reset");

    // Basic tone, one-cycle trigger latency.
    run(6, 1, "tone_start");
    chk("tone_start_const", 0, "wave",       {3'b0, bus_a.wave},       4'd1);
    chk("tone_start_const", 0, "note_start", {3'b0, bus_a.note_start}, 4'd1);
    chk("tone_start_const", 0, "cur_note",   bus_a.cur_note,           4'd6);
    run(6, 44, "tone_high");
    chk("tone_half44", 0, "wave", {3'b0, bus_a.wave}, 4'd0);
    run(6, 150, "tone");

    // Note change while playing.
    run(1, 1, "change_start");
    chk("change_const", 0, "note_start", {3'b0, bus_a.note_start}, 4'd1);
    run(1, 200, "change_hold");

    // Release tail after silence.
    run(6, 50, "pre_release");
    run(0, 1, "release_enter");
    chk("release_const", 0, "releasing", {3'b0, bus_a.releasing}, 4'd1);
    chk("release_const", 1, "active",    {3'b0, bus_b.active},    4'd0);
    run(0, 99, "release_tail");
    chk("release_last", 0, "releasing", {3'b0, bus_a.releasing}, 4'd1);
    run(0, 1, "release_end");
    chk("release_end_const", 0, "active", {3'b0, bus_a.active}, 4'd0);
    run(0, 10, "idle");

    // Retrigger during release: new note, then the same note again.
    run(6, 20, "retrig_pre");
    run(0, 30, "retrig_rel");
    run(8, 100, "retrig_new");
    run(0, 30, "retrig_rel2");
    run(8, 60, "retrig_same");
    run(6, 20, "retrig_other");
    run(0, 30, "retrig_rel3");
    run(6, 40, "retrig_six");
    run(0, 120, "retrig_drain");

    // Invalid codes, clamped pitch, immediate silence, reset mid-tone.
    run(12, 10, "invalid_idle");
    run(1, 20, "clamp");
    run(12, 3, "invalid_play");
    run(0, 110, "drain");
    run(3, 15, "pre_rst");
    rst_a = 1'b1;
    rst_b = 1'b1;
    run(3, 2, "rst_mid");
    rst_a = 1'b0;
    rst_b = 1'b0;
    run(0, 3, "post_rst");

    // Randomised note streams with occasional reset.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0:       code = 0;
        1:       code = $urandom_range(9, 15);
        default: code = $urandom_range(1, 8);
      endcase
      hold = $urandom_range(1, 60);
      if ($urandom_range(0, 29) == 0) begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        run(code, 1, "rand_rst");
        rst_a = 1'b0;
        rst_b = 1'b0;
      end
      run(code, hold, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
